// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Hazard and forwarding controller for the pipelined LEGv8 core.
//               Tracks in-flight destinations in a DEPTH-slot shift
//               scoreboard behind ID and produces load-use stalls, EX operand
//               forward selects, branch flushes and saturating stall/flush
//               performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter  int REG_W        = 5,
    parameter  int DEPTH        = 3,
    parameter  int ALU_READY    = 1,
    parameter  int LOAD_READY   = 2,
    parameter  int BRANCH_STAGE = 2,
    parameter  int ZERO_REG     = 31,
    parameter  int CNT_W        = 16,
    localparam int FW           = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             issue_valid,
    input  logic [REG_W-1:0] issue_rd,
    input  logic             issue_regwrite,
    input  logic             issue_memread,
    input  logic [REG_W-1:0] src_a,
    input  logic             src_a_used,
    input  logic [REG_W-1:0] src_b,
    input  logic             src_b_used,
    input  logic             branch_taken,
    output logic             stall_id,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [FW-1:0]    fwd_a_sel,
    output logic [FW-1:0]    fwd_b_sel,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [REG_W-1:0] c_zero_reg   = REG_W'(ZERO_REG);
    localparam logic [FW-1:0]    c_alu_ready  = FW'(ALU_READY);
    localparam logic [FW-1:0]    c_load_ready = FW'(LOAD_READY);

    // Scoreboard slots: index k is the instruction k stages ahead of ID.
    logic [DEPTH:1]   slot_valid_q, slot_valid_d;
    logic [DEPTH:1]   slot_rw_q,    slot_rw_d;
    logic [DEPTH:1]   slot_mr_q,    slot_mr_d;
    logic [REG_W-1:0] slot_rd_q [1:DEPTH];
    logic [REG_W-1:0] slot_rd_d [1:DEPTH];

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [DEPTH:1]   w_producer;
    logic             w_hazard_a;
    logic             w_hazard_b;
    logic             w_stall;
    logic             w_accept;
    logic [FW-1:0]    w_fwd_a;
    logic [FW-1:0]    w_fwd_b;

    // A slot only produces a value worth tracking if it really writes a
    // register other than XZR.
    generate
        for (genvar k = 1; k <= DEPTH; k++) begin : g_producer
            assign w_producer[k] = slot_valid_q[k] & slot_rw_q[k] &
                                   (slot_rd_q[k] != c_zero_reg);
        end
    endgenerate

    // Identical match/readiness logic for both source operands.
    generate
        for (genvar o = 0; o < 2; o++) begin : g_operand
            logic [REG_W-1:0] w_src;
            logic             w_en;
            logic             w_hit;
            logic             w_is_load;
            logic [FW-1:0]    w_slot;
            logic             w_ready;
            logic [FW-1:0]    w_fwd;
            logic             w_hazard;

            assign w_src = (o == 0) ? src_a : src_b;
            assign w_en  = ((o == 0) ? src_a_used : src_b_used) &
                           (w_src != c_zero_reg);

            // Scan oldest to youngest so the last hit is the youngest producer.
            always_comb begin
                w_hit     = 1'b0;
                w_is_load = 1'b0;
                w_slot    = '0;
                for (int k = DEPTH; k >= 1; k--) begin
                    if (w_en && w_producer[k] && (slot_rd_q[k] == w_src)) begin
                        w_hit     = 1'b1;
                        w_is_load = slot_mr_q[k];
                        w_slot    = FW'(k);
                    end
                end
            end

            assign w_ready  = w_slot >= (w_is_load ? c_load_ready : c_alu_ready);
            assign w_fwd    = (w_hit && w_ready) ? w_slot : '0;
            assign w_hazard = issue_valid & w_hit & ~w_ready;
        end
    endgenerate

    assign w_hazard_a = g_operand[0].w_hazard;
    assign w_hazard_b = g_operand[1].w_hazard;
    assign w_fwd_a    = g_operand[0].w_fwd;
    assign w_fwd_b    = g_operand[1].w_fwd;

    // A taken branch overrides any pending stall: the ID instruction is
    // squashed anyway, so holding it would only waste a cycle.
    assign w_stall  = (w_hazard_a | w_hazard_b) & ~branch_taken;
    assign w_accept = issue_valid & ~w_stall & ~branch_taken;

    // Next scoreboard state: shift one slot, fill slot 1, clear wrong-path slots.
    always_comb begin
        slot_valid_d = '0;
        slot_rw_d    = '0;
        slot_mr_d    = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            slot_rd_d[k] = '0;
        end

        slot_valid_d[1] = w_accept;
        slot_rw_d[1]    = issue_regwrite;
        slot_mr_d[1]    = issue_memread;
        slot_rd_d[1]    = issue_rd;

        for (int k = 2; k <= DEPTH; k++) begin
            slot_valid_d[k] = slot_valid_q[k-1];
            slot_rw_d[k]    = slot_rw_q[k-1];
            slot_mr_d[k]    = slot_mr_q[k-1];
            slot_rd_d[k]    = slot_rd_q[k-1];
            // Slots 2..BRANCH_STAGE now hold instructions fetched after the
            // branch; the branch itself lands in BRANCH_STAGE+1 untouched.
            if (branch_taken && (k <= BRANCH_STAGE)) begin
                slot_valid_d[k] = 1'b0;
            end
        end
    end

    // Saturating counters: hold at all-ones rather than wrap.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (w_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (branch_taken && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State registers; asynchronous reset empties the pipe and clears counters.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            slot_valid_q <= '0;
            slot_rw_q    <= '0;
            slot_mr_q    <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                slot_rd_q[k] <= '0;
            end
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_rw_q    <= slot_rw_d;
            slot_mr_q    <= slot_mr_d;
            for (int k = 1; k <= DEPTH; k++) begin
                slot_rd_q[k] <= slot_rd_d[k];
            end
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign stall_id    = w_stall;
    assign pc_write    = ~w_stall;
    assign ifid_write  = ~w_stall;
    assign flush_ifid  = branch_taken;
    assign flush_idex  = branch_taken;
    assign fwd_a_sel   = w_fwd_a;
    assign fwd_b_sel   = w_fwd_b;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Self-checking bench for hazard_scoreboard: directed vector
//               table, hand-written reset/saturation sequences and a
//               randomized run against an in-flight-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       issue_valid = 1'b0;
    logic [4:0] issue_rd = '0;
    logic       issue_regwrite = 1'b0;
    logic       issue_memread = 1'b0;
    logic [4:0] src_a = '0;
    logic       src_a_used = 1'b0;
    logic [4:0] src_b = '0;
    logic       src_b_used = 1'b0;
    logic       branch_taken = 1'b0;

    logic        stall_id, pc_write, ifid_write, flush_ifid, flush_idex;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_count, flush_count;

    logic        s_stall_id, s_pc_write, s_ifid_write, s_flush_ifid, s_flush_idex;
    logic [1:0]  s_fwd_a_sel, s_fwd_b_sel;
    logic [3:0]  s_stall_count, s_flush_count;

    int n_pass  = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    hazard_scoreboard u_dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_regwrite(issue_regwrite), .issue_memread(issue_memread),
        .src_a(src_a), .src_a_used(src_a_used),
        .src_b(src_b), .src_b_used(src_b_used),
        .branch_taken(branch_taken),
        .stall_id(stall_id), .pc_write(pc_write), .ifid_write(ifid_write),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    // Narrow-counter copy so saturation is reachable in a short run.
    hazard_scoreboard #(.CNT_W(4)) u_sat (
        .CLK(CLK), .RESET_N(RESET_N),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_regwrite(issue_regwrite), .issue_memread(issue_memread),
        .src_a(src_a), .src_a_used(src_a_used),
        .src_b(src_b), .src_b_used(src_b_used),
        .branch_taken(branch_taken),
        .stall_id(s_stall_id), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
        .flush_ifid(s_flush_ifid), .flush_idex(s_flush_idex),
        .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic drive(input int v, input int rd, input int rw, input int mr,
                         input int a, input int au, input int b, input int bu,
                         input int br);
        issue_valid    = v[0];
        issue_rd       = rd[4:0];
        issue_regwrite = rw[0];
        issue_memread  = mr[0];
        src_a          = a[4:0];
        src_a_used     = au[0];
        src_b          = b[4:0];
        src_b_used     = bu[0];
        branch_taken   = br[0];
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET_N = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int v, rd, rw, mr, a, au, b, bu, br;
        int e_stall, e_fa, e_fb, e_flush, e_scnt, e_fcnt;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(int v, int rd, int rw, int mr, int a, int au,
                                int b, int bu, int br, int es, int efa,
                                int efb, int efl, int esc, int efc);
        vec_t t;
        t.v = v; t.rd = rd; t.rw = rw; t.mr = mr; t.a = a; t.au = au;
        t.b = b; t.bu = bu; t.br = br; t.e_stall = es; t.e_fa = efa;
        t.e_fb = efb; t.e_flush = efl; t.e_scnt = esc; t.e_fcnt = efc;
        return t;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int       age;
        logic [4:0] rd;
        bit       wr;
        bit       ld;
    } ent_t;

    ent_t inflight[$];

    function automatic void lookup(input logic [4:0] src, input bit used,
                                   output int sel, output bit haz);
        int best;
        int need;
        sel  = 0;
        haz  = 1'b0;
        best = -1;
        if (!used || src == 5'd31) return;
        foreach (inflight[i]) begin
            if (inflight[i].wr && inflight[i].rd != 5'd31 && inflight[i].rd == src &&
                (best < 0 || inflight[i].age < inflight[best].age))
                best = i;
        end
        if (best < 0) return;
        need = inflight[best].ld ? 2 : 1;
        if (inflight[best].age >= need) sel = inflight[best].age;
        else haz = 1'b1;
    endfunction

    function automatic void advance(input bit accepted, input bit br,
                                    input logic [4:0] rd, input bit wr, input bit ld);
        ent_t nq[$];
        ent_t e;
        foreach (inflight[i]) begin
            e = inflight[i];
            e.age = e.age + 1;
            if (e.age <= 3 && !(br && e.age >= 2 && e.age <= 2)) nq.push_back(e);
        end
        if (accepted) begin
            e.age = 1; e.rd = rd; e.wr = wr; e.ld = ld;
            nq.push_back(e);
        end
        inflight = nq;
    endfunction

    function automatic logic [4:0] pick_reg();
        int r;
        r = $urandom_range(0, 8);
        return (r == 8) ? 5'd31 : 5'(r);
    endfunction

    initial begin
        tbl[0]  = mk(1, 1, 1,0,  0,0,  0,0, 0,  0,0,0,0, 0,0);
        tbl[1]  = mk(1, 2, 1,0,  1,1,  1,1, 0,  0,1,1,0, 0,0);
        tbl[2]  = mk(1, 3, 1,1,  2,1,  0,0, 0,  0,1,0,0, 0,0);
        tbl[3]  = mk(1, 4, 1,0,  3,1,  5,1, 0,  1,0,0,0, 0,0);
        tbl[4]  = mk(1, 4, 1,0,  3,1,  5,1, 0,  0,2,0,0, 1,0);
        tbl[5]  = mk(1,31, 1,0,  4,1, 31,1, 0,  0,1,0,0, 1,0);
        tbl[6]  = mk(1, 5, 1,0, 31,1,  4,1, 0,  0,0,2,0, 1,0);
        tbl[7]  = mk(1, 5, 1,0,  4,1,  0,0, 0,  0,3,0,0, 1,0);
        tbl[8]  = mk(1, 6, 1,1,  5,1,  5,1, 0,  0,1,1,0, 1,0);
        tbl[9]  = mk(1, 8, 1,0,  6,1,  5,1, 1,  0,0,2,1, 1,0);
        tbl[10] = mk(1, 0, 0,0,  6,1,  5,1, 0,  0,0,3,0, 1,1);
        tbl[11] = mk(1, 7, 1,1,  5,1,  0,0, 0,  0,0,0,0, 1,1);
        tbl[12] = mk(0, 0, 0,0,  7,1,  0,0, 0,  0,0,0,0, 1,1);
        tbl[13] = mk(1, 0, 0,0,  7,1,  7,1, 0,  0,2,2,0, 1,1);

        // Reset state.
        #1;
        chk("rst_stall", stall_id, 0);
        chk("rst_pc_write", pc_write, 1);
        chk("rst_ifid_write", ifid_write, 1);
        chk("rst_fwd_a", fwd_a_sel, 0);
        chk("rst_stall_count", stall_count, 0);
        chk("rst_flush_count", flush_count, 0);
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Directed table, one entry per cycle.
        for (int i = 0; i < 14; i++) begin
            if (i > 0) @(negedge CLK);
            drive(tbl[i].v, tbl[i].rd, tbl[i].rw, tbl[i].mr, tbl[i].a,
                  tbl[i].au, tbl[i].b, tbl[i].bu, tbl[i].br);
            #1;
            chk($sformatf("v%0d_stall", i), stall_id, tbl[i].e_stall);
            chk($sformatf("v%0d_pc_write", i), pc_write, 1 - tbl[i].e_stall);
            chk($sformatf("v%0d_ifid_write", i), ifid_write, 1 - tbl[i].e_stall);
            chk($sformatf("v%0d_fwd_a", i), fwd_a_sel, tbl[i].e_fa);
            chk($sformatf("v%0d_fwd_b", i), fwd_b_sel, tbl[i].e_fb);
            chk($sformatf("v%0d_flush_ifid", i), flush_ifid, tbl[i].e_flush);
            chk($sformatf("v%0d_flush_idex", i), flush_idex, tbl[i].e_flush);
            chk($sformatf("v%0d_stall_count", i), stall_count, tbl[i].e_scnt);
            chk($sformatf("v%0d_flush_count", i), flush_count, tbl[i].e_fcnt);
        end

        // Reset asserted in the middle of a load-use stall.
        @(negedge CLK); drive(1, 1, 1, 0, 0, 0, 0, 0, 0);
        @(negedge CLK); drive(1, 2, 1, 0, 0, 0, 0, 0, 0);
        @(negedge CLK); drive(1, 3, 1, 1, 0, 0, 0, 0, 0);
        @(negedge CLK); drive(1, 0, 0, 0, 3, 1, 1, 1, 0);
        #1;
        chk("mid_stall_before_reset", stall_id, 1);
        RESET_N = 1'b0;
        #1;
        chk("inrst_stall", stall_id, 0);
        chk("inrst_pc_write", pc_write, 1);
        chk("inrst_ifid_write", ifid_write, 1);
        chk("inrst_fwd_a", fwd_a_sel, 0);
        chk("inrst_fwd_b", fwd_b_sel, 0);
        chk("inrst_stall_count", stall_count, 0);
        chk("inrst_flush_count", flush_count, 0);
        chk("inrst_sat_stall_count", s_stall_count, 0);
        branch_taken = 1'b1;
        #1;
        chk("inrst_flush_ifid", flush_ifid, 1);
        chk("inrst_flush_idex", flush_idex, 1);
        branch_taken = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        #1;
        chk("postrst_stall", stall_id, 0);
        chk("postrst_fwd_a", fwd_a_sel, 0);
        chk("postrst_fwd_b", fwd_b_sel, 0);

        // Repeated self-dependent loads: stall every other cycle.
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            drive(1, 3, 1, 1, 3, 1, 0, 0, 0);
            #1;
            chk($sformatf("sat_stall_%0d", i), stall_id, i % 2);
        end
        @(negedge CLK);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("stall_count_20", stall_count, 20);
        chk("sat_stall_count_hold", s_stall_count, 15);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        end
        @(negedge CLK);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("flush_count_20", flush_count, 20);
        chk("sat_flush_count_hold", s_flush_count, 15);
        chk("sat_stall_count_still", s_stall_count, 15);

        // Randomized run against the in-flight-list model.
        do_reset();
        inflight.delete();
        begin
            int   ms, mf, mss, msf;
            int   sel_a, sel_b;
            bit   haz_a, haz_b, e_stall, acc;
            ms = 0; mf = 0; mss = 0; msf = 0;
            for (int cyc = 0; cyc < 500; cyc++) begin
                if (cyc > 0) @(negedge CLK);
                issue_valid    = ($urandom_range(0, 7) != 0);
                issue_rd       = pick_reg();
                issue_regwrite = ($urandom_range(0, 3) != 0);
                issue_memread  = ($urandom_range(0, 2) == 0);
                src_a          = pick_reg();
                src_a_used     = ($urandom_range(0, 3) != 0);
                src_b          = pick_reg();
                src_b_used     = ($urandom_range(0, 1) != 0);
                branch_taken   = ($urandom_range(0, 9) == 0);
                lookup(src_a, src_a_used, sel_a, haz_a);
                lookup(src_b, src_b_used, sel_b, haz_b);
                e_stall = issue_valid && (haz_a || haz_b) && !branch_taken;
                acc     = issue_valid && !e_stall && !branch_taken;
                #1;
                chk("rnd_stall", stall_id, e_stall);
                chk("rnd_pc_write", pc_write, !e_stall);
                chk("rnd_fwd_a", fwd_a_sel, sel_a);
                chk("rnd_fwd_b", fwd_b_sel, sel_b);
                chk("rnd_flush_idex", flush_idex, branch_taken);
                chk("rnd_stall_count", stall_count, ms);
                chk("rnd_flush_count", flush_count, mf);
                chk("rnd_sat_stall_count", s_stall_count, mss);
                chk("rnd_sat_flush_count", s_flush_count, msf);
                if (e_stall) begin
                    if (ms < 65535) ms++;
                    if (mss < 15) mss++;
                end
                if (branch_taken) begin
                    if (mf < 65535) mf++;
                    if (msf < 15) msf++;
                end
                advance(acc, branch_taken, issue_rd, issue_regwrite, issue_memread);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
